// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV M-extension multiply/divide unit: funct3
// opcode encodings, control FSM states and the default datapath width.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // All divide/remainder encodings have funct3 bit 2 set.
    function automatic logic is_div_op(input op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Magnitude restoring divider: loads on start_i, then produces one quotient
// bit per cycle for XLEN cycles and holds done_o until the next start/abort.
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int CNT_W = $clog2(XLEN + 1);

    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvsr_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;

    assign shifted     = {rem_q, quo_q[XLEN-1]};
    assign diff        = shifted - {1'b0, dvsr_q};
    assign done_o      = busy_q && (count_q == CNT_W'(XLEN));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

    // Shift in one dividend bit per cycle; keep the trial subtraction unless it went negative.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else if (abort_i) begin
            count_q <= '0;
            busy_q  <= 1'b0;
        end else if (start_i) begin
            quo_q   <= dividend_i;
            rem_q   <= '0;
            dvsr_q  <= divisor_i;
            count_q <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q && !done_o) begin
            if (diff[XLEN]) begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end else begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV M-extension multiply/divide unit with IDLE/BUSY/DONE handshake.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; otherwise the
// multiply ops use an iterative shift-add datapath. Divide is always iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            ready_o,
    output logic            valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int              CNT_W    = $clog2(XLEN + 2);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    op_e               op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept, is_div;
    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, div_special;
    logic              core_start, core_done;
    logic [XLEN-1:0]   core_quo, core_rem;
    logic [2*XLEN-1:0] prod_full;
    logic              mul_finish, finish;
    logic [XLEN-1:0]   mul_res, div_res;

    assign accept = (state_q == ST_IDLE) && start_i && !kill_i;
    assign is_div = is_div_op(op_q);

    assign a_sgn = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                   (op_q == OP_DIV) || (op_q == OP_REM);
    assign b_sgn = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    assign a_neg = a_sgn && a_q[XLEN-1];
    assign b_neg = b_sgn && b_q[XLEN-1];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;

    assign div_zero    = (b_q == '0);
    assign div_ovf     = ((op_q == OP_DIV) || (op_q == OP_REM)) && (a_q == MOST_NEG) && (b_q == '1);
    assign div_special = div_zero || div_ovf;

    // The first BUSY cycle kicks the divider with operand magnitudes.
    assign core_start = (state_q == ST_BUSY) && (cnt_q == '0) && is_div && !div_special;

    muldiv_div_core #(.XLEN(XLEN)) u_div_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (core_start),
        .abort_i     (kill_i),
        .dividend_i  (a_mag),
        .divisor_i   (b_mag),
        .done_o      (core_done),
        .quotient_o  (core_quo),
        .remainder_o (core_rem)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] a_ext, b_ext;

    assign a_ext      = {{XLEN{a_neg}}, a_q};
    assign b_ext      = {{XLEN{b_neg}}, b_q};
    assign prod_full  = a_ext * b_ext;
    assign mul_finish = (cnt_q == CNT_W'(1));
`else
    logic [2*XLEN-1:0] mcand_q, prod_q;
    logic [XLEN-1:0]   mplier_q;

    assign prod_full  = (a_neg ^ b_neg) ? -prod_q : prod_q;
    assign mul_finish = (cnt_q == CNT_W'(XLEN + 1));

    // Shift-add on magnitudes: load on the first BUSY cycle, then one multiplier bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else if ((state_q == ST_BUSY) && !is_div) begin
            if (cnt_q == '0) begin
                mcand_q  <= {{XLEN{1'b0}}, a_mag};
                mplier_q <= b_mag;
                prod_q   <= '0;
            end else begin
                if (mplier_q[0]) begin
                    prod_q <= prod_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end
`endif

    assign mul_res = (op_q == OP_MUL) ? prod_full[XLEN-1:0] : prod_full[2*XLEN-1:XLEN];

    // Sign fixup for divide: quotient negative on differing signs, remainder follows the dividend.
    always_comb begin
        div_res = '0;
        if (div_zero) begin
            div_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? '1 : a_q;
        end else if (div_ovf) begin
            div_res = (op_q == OP_DIV) ? a_q : '0;
        end else if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
            div_res = (a_neg ^ b_neg) ? -core_quo : core_quo;
        end else begin
            div_res = a_neg ? -core_rem : core_rem;
        end
    end

    assign finish = is_div ? (div_special ? (cnt_q == CNT_W'(1)) : (core_done && (cnt_q != '0)))
                           : mul_finish;

    // Capture the request on acceptance and count BUSY cycles from there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_MUL;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            op_q  <= op_e'(op_i);
            a_q   <= a_i;
            b_q   <= b_i;
            cnt_q <= '0;
        end else if (state_q == ST_BUSY) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // FSM state and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    // Next-state logic; kill wins over both a new start and a result handshake.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (finish) begin
                    state_d  = ST_DONE;
                    result_d = is_div ? div_res : mul_res;
                end
            end
            ST_DONE: begin
                if (result_ready_i) begin
                    state_d  = ST_IDLE;
                    result_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (kill_i) begin
            state_d  = ST_IDLE;
            result_d = '0;
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign valid_o  = (state_q == ST_DONE);
    assign result_o = valid_o ? result_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed vectors with
// literal expectations plus an arithmetic reference model compared every cycle.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat = 2;
`else
    localparam int MulLat = XLEN + 2;
`endif

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opA, opB;
    logic        kill;
    logic        resultReady;
    logic        ready, valid;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    int          lat;
    logic [31:0] res;
    logic        sawValid;

    int          mPhase = 0;
    int          mLeft  = 0;
    logic [31:0] mRes   = '0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rstN),
        .start_i        (start),
        .op_i           (op),
        .a_i            (opA),
        .b_i            (opB),
        .kill_i         (kill),
        .ready_o        (ready),
        .valid_o        (valid),
        .result_ready_i (resultReady),
        .result_o       (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Architectural result of an M-extension op, from plain 64-bit arithmetic.
    function automatic logic [31:0] modelResult(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        longint            sx, sy, p;
        logic [63:0]       up;
        logic signed [31:0] q;
        logic              ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f3)
            3'b000: begin p = sx * sy; return p[31:0]; end
            3'b001: begin p = sx * sy; return p[63:32]; end
            3'b010: begin p = sx * longint'({32'd0, y}); return p[63:32]; end
            3'b011: begin up = {32'd0, x} * {32'd0, y}; return up[63:32]; end
            3'b100: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return x;
                q = $signed(x) / $signed(y);
                return q;
            end
            3'b101: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'b110: begin
                if (y == 0) return x;
                if (ovf) return 32'd0;
                q = $signed(x) % $signed(y);
                return q;
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    // Cycles from acceptance edge to the first valid edge.
    function automatic int modelLatency(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        if (f3[2]) begin
            if (y == 0) return 2;
            if (((f3 == 3'b100) || (f3 == 3'b110)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) return 2;
            return XLEN + 2;
        end
        return MulLat;
    endfunction

    // Reference model: phase 0 idle, 1 computing, 2 holding a result.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mPhase <= 0;
            mLeft  <= 0;
            mRes   <= '0;
        end else if (kill) begin
            mPhase <= 0;
        end else begin
            case (mPhase)
                0: if (start) begin
                    mPhase <= 1;
                    mLeft  <= modelLatency(op, opA, opB);
                    mRes   <= modelResult(op, opA, opB);
                end
                1: begin
                    if (mLeft == 1) mPhase <= 2;
                    mLeft <= mLeft - 1;
                end
                default: if (resultReady) mPhase <= 0;
            endcase
        end
    end

    // Every cycle the handshake and result bus must match the model.
    always @(negedge clk) begin
        checkOutput("cycle ready", 64'(ready), 64'(mPhase == 0));
        checkOutput("cycle valid", 64'(valid), 64'(mPhase == 2));
        checkOutput("cycle result", 64'(result), 64'((mPhase == 2) ? mRes : 32'd0));
    end

    // Issue one op, scramble the inputs while busy, measure latency, then hold and acknowledge.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                                 input int holdCycles, output int latency, output logic [31:0] got);
        int guard;
        guard   = 0;
        latency = 0;
        got     = '0;
        @(negedge clk);
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) checkOutput("ready timeout", 64'(ready), 64'd1);
        start = 1'b1;
        op    = f3;
        opA   = x;
        opB   = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~f3;
        opA   = ~x;
        opB   = ~y;
        while (!valid && latency < 200) begin
            @(posedge clk);
            latency++;
            #1;
        end
        if (!valid) begin
            checkOutput("valid timeout", 64'(valid), 64'd1);
            kill = 1'b1;
            @(posedge clk);
            #1;
            kill = 1'b0;
        end else begin
            got = result;
            for (int i = 0; i < holdCycles; i++) begin
                @(posedge clk);
                #1;
                checkOutput("hold result", 64'(result), 64'(got));
                checkOutput("hold ready", 64'(ready), 64'd0);
                checkOutput("hold valid", 64'(valid), 64'd1);
            end
            resultReady = 1'b1;
            @(posedge clk);
            #1;
            resultReady = 1'b0;
            checkOutput("ready after ack", 64'(ready), 64'd1);
            checkOutput("valid after ack", 64'(valid), 64'd0);
        end
    endtask

    // Extra vectors checked against the model only.
    logic [2:0]  tOp [8] = '{3'b010, 3'b001, 3'b000, 3'b101, 3'b111, 3'b100, 3'b110, 3'b110};
    logic [31:0] tA  [8] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'd100,
                             32'd100, 32'd7, 32'd7, 32'hFFFF_FFF8};
    logic [31:0] tB  [8] = '{32'd2, 32'h8000_0000, 32'd9, 32'd7,
                             32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd3};

    initial begin
        rstN = 1'b1; start = 1'b0; op = '0; opA = '0; opB = '0;
        kill = 1'b0; resultReady = 1'b0;
        #1 rstN = 1'b0;
        #2;
        checkOutput("reset ready", 64'(ready), 64'd1);
        checkOutput("reset valid", 64'(valid), 64'd0);
        checkOutput("reset result", 64'(result), 64'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;

        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, lat, res);
        checkOutput("DIV -7/2 result", 64'(res), 64'hFFFF_FFFD);
        checkOutput("DIV -7/2 latency", 64'(lat), 64'd34);
        applyStimulus(OP_REM, 32'hFFFF_FFF9, 32'd2, 0, lat, res);
        checkOutput("REM -7/2 result", 64'(res), 64'hFFFF_FFFF);

        applyStimulus(OP_DIVU, 32'h8000_0000, 32'd0, 0, lat, res);
        checkOutput("DIVU by 0 result", 64'(res), 64'hFFFF_FFFF);
        checkOutput("DIVU by 0 latency", 64'(lat), 64'd2);
        applyStimulus(OP_REMU, 32'h8000_0000, 32'd0, 0, lat, res);
        checkOutput("REMU by 0 result", 64'(res), 64'h8000_0000);
        checkOutput("REMU by 0 latency", 64'(lat), 64'd2);

        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, res);
        checkOutput("DIV ovf result", 64'(res), 64'h8000_0000);
        checkOutput("DIV ovf latency", 64'(lat), 64'd2);
        applyStimulus(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, res);
        checkOutput("REM ovf result", 64'(res), 64'd0);
        checkOutput("REM ovf latency", 64'(lat), 64'd2);

        applyStimulus(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, res);
        checkOutput("MULH -1*-1", 64'(res), 64'd0);
        checkOutput("MULH latency", 64'(lat), 64'(MulLat));
        applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, res);
        checkOutput("MULHU max*max", 64'(res), 64'hFFFF_FFFE);
        applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, res);
        checkOutput("MUL -1*-1", 64'(res), 64'd1);
        checkOutput("MUL latency", 64'(lat), 64'(MulLat));

        for (int i = 0; i < 8; i++) begin
            applyStimulus(tOp[i], tA[i], tB[i], 0, lat, res);
            checkOutput("table result", 64'(res), 64'(modelResult(tOp[i], tA[i], tB[i])));
            checkOutput("table latency", 64'(lat), 64'(modelLatency(tOp[i], tA[i], tB[i])));
        end

        applyStimulus(OP_DIVU, 32'd1000, 32'd3, 5, lat, res);
        checkOutput("stall DIVU result", 64'(res), 64'd333);

        // Kill during cycle 10 of a DIV.
        @(negedge clk);
        start = 1'b1; op = OP_DIV; opA = 32'd1000; opB = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        checkOutput("kill ready", 64'(ready), 64'd1);
        checkOutput("kill valid", 64'(valid), 64'd0);
        sawValid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) sawValid = 1'b1;
        end
        checkOutput("kill never valid", 64'(sawValid), 64'd0);

        // Reset pulse in the middle of a DIV.
        @(negedge clk);
        start = 1'b1; op = OP_DIV; opA = 32'd5000; opB = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rstN = 1'b0;
        #1;
        checkOutput("midrst ready", 64'(ready), 64'd1);
        checkOutput("midrst valid", 64'(valid), 64'd0);
        checkOutput("midrst result", 64'(result), 64'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        sawValid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) sawValid = 1'b1;
        end
        checkOutput("midrst never valid", 64'(sawValid), 64'd0);

        applyStimulus(OP_REMU, 32'd5000, 32'd7, 0, lat, res);
        checkOutput("post reset REMU", 64'(res), 64'd2);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus itself wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
